// File: rtl/data_stack.sv
// Operand stack for the stack-machine datapath.
// The top two entries sit in sr0/sr1; deeper entries live in a circular
// body array. On overflow the oldest body entry spills to data memory and
// is refilled from it (via a small REQ/WAIT handshake) as the stack drains.
module data_stack #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int SPILL_MAX = 1024
) (
  input  logic             clk,
  input  logic             async_reset,
  input  logic [3:0]       DSOP,
  input  logic [WIDTH-1:0] to_sr0,
  input  logic [WIDTH-1:0] to_sr1,
  input  logic             sr0_overwrite,
  input  logic             sr1_overwrite,
  output logic [WIDTH-1:0] from_sr0,
  output logic [WIDTH-1:0] from_sr1,
  output logic [4:0]       depth,
  output logic             data_stack_overflow,
  output logic             underflow,
  output logic             spill_valid,
  output logic [WIDTH-1:0] spill_data,
  output logic             fill_req,
  input  logic             fill_valid,
  input  logic [WIDTH-1:0] fill_data,
  output logic             busy,
  output logic             op_dropped
);
  localparam int N  = DEPTH - 2;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = PW + 7;
  localparam int CW = $clog2(SPILL_MAX + 1);
  localparam logic [4:0]    DEPTH_L  = 5'(DEPTH);
  localparam logic [4:0]    DEPTH_M1 = 5'(DEPTH - 1);
  localparam logic [CW-1:0] SPILL_L  = CW'(SPILL_MAX);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  // Reduce a pointer sum (always below 3*N) back into 0..N-1.
  function automatic logic [PW-1:0] mod_n(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    r = v;
    if (r >= SW'(2 * N))  r = r - SW'(2 * N);
    else if (r >= SW'(N)) r = r - SW'(N);
    return r[PW-1:0];
  endfunction

  state_t           state, state_n;
  logic [WIDTH-1:0] sr0, sr1, sr0_n, sr1_n;
  logic [4:0]       depth_q, depth_n, body_cnt;
  logic [CW-1:0]    spill_cnt;
  logic [PW-1:0]    bot, bot_n, top_idx, wr_idx, bot_inc, bot_dec;
  logic [WIDTH-1:0] body [N];
  logic             body_we;
  logic [PW-1:0]    body_wa;
  logic [WIDTH-1:0] body_wd;
  logic             spill_n, underflow_n, drop_n, op_act;

  assign body_cnt = (depth_q > 5'd2) ? depth_q - 5'd2 : 5'd0;
  assign top_idx  = mod_n(SW'(bot) + SW'(body_cnt) + SW'(N - 1));
  assign wr_idx   = mod_n(SW'(bot) + SW'(body_cnt));
  assign bot_inc  = mod_n(SW'(bot) + SW'(1));
  assign bot_dec  = mod_n(SW'(bot) + SW'(N - 1));
  assign op_act   = (|DSOP) || sr0_overwrite || sr1_overwrite;

  // Next-state decode: stack op + overwrite strobes in IDLE, refill insert in WAIT.
  always_comb begin
    state_n     = state;
    sr0_n       = sr0;
    sr1_n       = sr1;
    depth_n     = depth_q;
    bot_n       = bot;
    body_we     = 1'b0;
    body_wa     = wr_idx;
    body_wd     = sr1;
    spill_n     = 1'b0;
    underflow_n = 1'b0;
    drop_n      = 1'b0;
    case (state)
      S_IDLE: begin
        if (DSOP[3:2] == 2'b01) begin
          sr1_n = sr0;
          if (DSOP[1]) sr0_n = to_sr0;
          if (depth_q >= 5'd2) body_we = 1'b1;
          if (depth_q == DEPTH_L) begin
            // Full: evict the oldest entry and reuse its slot as the new top.
            spill_n = 1'b1;
            body_wa = bot;
            bot_n   = bot_inc;
          end else begin
            depth_n = depth_q + 5'd1;
          end
        end else if (DSOP[3:2] == 2'b10) begin
          if (depth_q == 5'd0) begin
            underflow_n = 1'b1;
          end else begin
            sr0_n   = (depth_q == 5'd1) ? '0 : sr1;
            sr1_n   = (depth_q > 5'd2) ? body[top_idx] : '0;
            depth_n = depth_q - 5'd1;
            if (depth_q == DEPTH_L && spill_cnt != '0) state_n = S_REQ;
          end
        end else if (DSOP[1]) begin
          sr0_n = to_sr0;
          if (DSOP[3:2] == 2'b00) sr1_n = to_sr1;
        end
        if (sr0_overwrite) sr0_n = to_sr0;
        if (sr1_overwrite) sr1_n = to_sr1;
      end
      S_REQ: begin
        drop_n  = op_act;
        state_n = S_WAIT;
      end
      default: begin
        drop_n = op_act;
        if (fill_valid) begin
          // Refilled word is older than everything on chip: insert below bottom.
          body_we = 1'b1;
          body_wa = bot_dec;
          body_wd = fill_data;
          bot_n   = bot_dec;
          depth_n = depth_q + 5'd1;
          state_n = S_IDLE;
        end
      end
    endcase
  end

  // Control and top-of-stack registers, with registered strobes.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state               <= S_IDLE;
      sr0                 <= '0;
      sr1                 <= '0;
      depth_q             <= '0;
      bot                 <= '0;
      spill_cnt           <= '0;
      spill_valid         <= 1'b0;
      spill_data          <= '0;
      data_stack_overflow <= 1'b0;
      underflow           <= 1'b0;
      fill_req            <= 1'b0;
      busy                <= 1'b0;
      op_dropped          <= 1'b0;
    end else begin
      state               <= state_n;
      sr0                 <= sr0_n;
      sr1                 <= sr1_n;
      depth_q             <= depth_n;
      bot                 <= bot_n;
      spill_valid         <= spill_n;
      data_stack_overflow <= spill_n;
      underflow           <= underflow_n;
      op_dropped          <= drop_n;
      fill_req            <= (state_n == S_REQ);
      busy                <= (state_n != S_IDLE);
      if (spill_n) spill_data <= body[bot];
      if (spill_n && spill_cnt != SPILL_L) spill_cnt <= spill_cnt + 1'b1;
      else if (state == S_REQ)             spill_cnt <= spill_cnt - 1'b1;
    end
  end

  // Body array storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (body_we) body[body_wa] <= body_wd;
  end

  assign from_sr0 = sr0;
  assign from_sr1 = sr1;
  assign depth    = depth_q;

  logic unused_depth_m1;
  assign unused_depth_m1 = ^DEPTH_M1;
endmodule

// File: tb/tb_data_stack.sv
// Bench for data_stack: directed scenarios followed by randomized traffic,
// all checked against a queue-based reference model of the stack.
module tb_data_stack;
  localparam int W  = 16;
  localparam int D  = 16;
  localparam int SM = 1024;

  logic          clk = 1'b0;
  logic          async_reset;
  logic [3:0]    dsop;
  logic [W-1:0]  to0, to1, fd;
  logic          ow0, ow1, fv;
  logic [W-1:0]  from_sr0, from_sr1, spill_data;
  logic [4:0]    depth;
  logic          ovf, udf, spv, frq, busy, drop;

  data_stack #(.WIDTH(W), .DEPTH(D), .SPILL_MAX(SM)) dut (
    .clk(clk), .async_reset(async_reset), .DSOP(dsop),
    .to_sr0(to0), .to_sr1(to1), .sr0_overwrite(ow0), .sr1_overwrite(ow1),
    .from_sr0(from_sr0), .from_sr1(from_sr1), .depth(depth),
    .data_stack_overflow(ovf), .underflow(udf), .spill_valid(spv),
    .spill_data(spill_data), .fill_req(frq), .fill_valid(fv),
    .fill_data(fd), .busy(busy), .op_dropped(drop)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: registers for the top two, queues for body and memory.
  logic [W-1:0] m_sr0, m_sr1, pending;
  logic [W-1:0] mbody[$];
  logic [W-1:0] mmem[$];
  int           mdepth, mst;
  logic         e_ovf, e_spv, e_udf, e_drop;
  logic [W-1:0] e_spd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_sr0 = '0; m_sr1 = '0; mdepth = 0; mst = 0;
    mbody.delete(); mmem.delete();
    e_ovf = 0; e_spv = 0; e_udf = 0; e_drop = 0; e_spd = '0;
  endtask

  task automatic model_step();
    logic [W-1:0] n0, n1;
    logic act;
    act = (dsop != 4'd0) || ow0 || ow1;
    e_ovf = 0; e_spv = 0; e_udf = 0; e_drop = 0;
    if (mst == 0) begin
      n0 = m_sr0; n1 = m_sr1;
      if (dsop[3:2] == 2'b01) begin
        if (mdepth >= 2) mbody.push_back(m_sr1);
        if (mdepth == D) begin
          e_spd = mbody.pop_front(); e_spv = 1; e_ovf = 1;
          if (mmem.size() < SM) mmem.push_back(e_spd);
        end else mdepth++;
        n1 = m_sr0;
        if (dsop[1]) n0 = to0;
      end else if (dsop[3:2] == 2'b10) begin
        if (mdepth == 0) e_udf = 1;
        else begin
          n0 = (mdepth == 1) ? '0 : m_sr1;
          n1 = (mdepth > 2) ? mbody.pop_back() : '0;
          mdepth--;
          if (mdepth == D - 1 && mmem.size() > 0) mst = 1;
        end
      end else if (dsop[3:2] == 2'b00 && dsop[1]) begin
        n0 = to0; n1 = to1;
      end else if (dsop[3:2] == 2'b11 && dsop[1]) begin
        n0 = to0;
      end
      if (ow0) n0 = to0;
      if (ow1) n1 = to1;
      m_sr0 = n0; m_sr1 = n1;
    end else if (mst == 1) begin
      e_drop = act;
      pending = mmem.pop_back();
      mst = 2;
    end else begin
      e_drop = act;
      if (fv) begin
        mbody.push_front(fd);
        mdepth++;
        mst = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("from_sr0", 32'(from_sr0), 32'(m_sr0));
    chk("from_sr1", 32'(from_sr1), 32'(m_sr1));
    chk("depth", 32'(depth), 32'(mdepth));
    chk("overflow", 32'(ovf), 32'(e_ovf));
    chk("spill_valid", 32'(spv), 32'(e_spv));
    if (e_spv) chk("spill_data", 32'(spill_data), 32'(e_spd));
    chk("underflow", 32'(udf), 32'(e_udf));
    chk("fill_req", 32'(frq), 32'(mst == 1));
    chk("busy", 32'(busy), 32'(mst != 0));
    chk("op_dropped", 32'(drop), 32'(e_drop));
  endtask

  task automatic cyc(input logic [3:0] d, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic o0, input logic o1, input logic f, input logic [W-1:0] fdat);
    dsop = d; to0 = a; to1 = b; ow0 = o0; ow1 = o1; fv = f; fd = fdat;
    model_step();
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_sr0"}, 32'(from_sr0), 32'd0);
    chk({tag, "_sr1"}, 32'(from_sr1), 32'd0);
    chk({tag, "_depth"}, 32'(depth), 32'd0);
    chk({tag, "_pulses"}, 32'({ovf, udf, spv, frq, drop}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    dsop = '0; to0 = '0; to1 = '0; ow0 = 0; ow1 = 0; fv = 0; fd = '0;
    #2 async_reset = 1'b1;
    #1 reset_check(tag);
    model_reset();
    @(posedge clk); #1;
    async_reset = 1'b0;
    #1;
  endtask

  initial begin
    async_reset = 1'b0;
    dsop = '0; to0 = '0; to1 = '0; ow0 = 0; ow1 = 0; fv = 0; fd = '0;
    pending = '0;
    model_reset();
    #3;
    do_reset("reset");

    // Basic push/push/pop.
    cyc(4'b0110, 16'h0005, 16'h0, 0, 0, 0, 16'h0);
    cyc(4'b0110, 16'h0007, 16'h0, 0, 0, 0, 16'h0);
    chk("push2_sr0", 32'(from_sr0), 32'h7);
    chk("push2_sr1", 32'(from_sr1), 32'h5);
    chk("push2_depth", 32'(depth), 32'd2);
    cyc(4'b1001, 16'h0, 16'h0, 0, 0, 0, 16'h0);
    chk("pop_sr0", 32'(from_sr0), 32'h5);
    chk("pop_sr1", 32'(from_sr1), 32'h0);
    chk("pop_depth", 32'(depth), 32'd1);
    cyc(4'b1000, 16'h0, 16'h0, 0, 0, 0, 16'h0);

    // Fill to overflow.
    for (int i = 1; i <= 17; i++) cyc(4'b0110, 16'(i), 16'h0, 0, 0, 0, 16'h0);
    chk("ovf_spill_valid", 32'(spv), 32'd1);
    chk("ovf_spill_data", 32'(spill_data), 32'd1);
    chk("ovf_pulse", 32'(ovf), 32'd1);
    chk("ovf_depth", 32'(depth), 32'd16);
    chk("ovf_sr0", 32'(from_sr0), 32'd17);

    // Pop triggers refill; push during REQ is dropped.
    cyc(4'b1000, 16'h0, 16'h0, 0, 0, 0, 16'h0);
    chk("fill_req", 32'(frq), 32'd1);
    chk("fill_busy", 32'(busy), 32'd1);
    cyc(4'b0110, 16'h0055, 16'h0, 0, 0, 0, 16'h0);
    chk("drop_pulse", 32'(drop), 32'd1);
    chk("drop_depth", 32'(depth), 32'd15);
    chk("drop_sr0", 32'(from_sr0), 32'd16);
    cyc(4'b0000, 16'h0, 16'h0, 0, 0, 1, pending);
    chk("fill_done_busy", 32'(busy), 32'd0);
    chk("fill_done_depth", 32'(depth), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("pop_order", 32'(from_sr0), 32'(16 - i));
      cyc(4'b1000, 16'h0, 16'h0, 0, 0, 0, 16'h0);
    end
    cyc(4'b1000, 16'h0, 16'h0, 0, 0, 0, 16'h0);
    chk("underflow", 32'(udf), 32'd1);
    chk("underflow_sr0", 32'(from_sr0), 32'd0);
    chk("underflow_depth", 32'(depth), 32'd0);

    // Write-swap, then overwrite alongside pop.
    cyc(4'b0110, 16'h0003, 16'h0, 0, 0, 0, 16'h0);
    cyc(4'b0110, 16'h0010, 16'h0, 0, 0, 0, 16'h0);
    cyc(4'b0010, 16'h0003, 16'h0010, 0, 0, 0, 16'h0);
    chk("swap_sr0", 32'(from_sr0), 32'h3);
    chk("swap_sr1", 32'(from_sr1), 32'h10);
    chk("swap_depth", 32'(depth), 32'd2);
    cyc(4'b1000, 16'h000D, 16'h0, 1, 0, 0, 16'h0);
    chk("ow_sr0", 32'(from_sr0), 32'hD);
    chk("ow_depth", 32'(depth), 32'd1);

    // Randomized traffic in alternating push-heavy / pop-heavy phases.
    for (int ph = 0; ph < 8; ph++) begin
      int pw, pp;
      pw = (ph % 2 == 0) ? 60 : 20;
      pp = (ph % 2 == 0) ? 20 : 60;
      for (int n = 0; n < 300; n++) begin
        int r;
        logic [3:0] d;
        logic f;
        logic [W-1:0] fdat;
        r = $urandom_range(0, 99);
        if (r < pw)           d = 4'b0100 | 4'($urandom_range(0, 3));
        else if (r < pw + pp) d = 4'b1000 | 4'($urandom_range(0, 3));
        else                  d = 4'($urandom_range(0, 15));
        if (mst == 2) begin
          f = ($urandom_range(0, 2) == 0);
          fdat = pending;
        end else begin
          f = ($urandom_range(0, 7) == 0);
          fdat = 16'($urandom);
        end
        cyc(d, 16'($urandom), 16'($urandom), $urandom_range(0, 15) == 0,
            $urandom_range(0, 15) == 0, f, fdat);
      end
    end

    // Async reset in the middle of WAIT; a late fill_valid is ignored.
    do_reset("reset2");
    for (int i = 1; i <= 17; i++) cyc(4'b0110, 16'(i + 100), 16'h0, 0, 0, 0, 16'h0);
    cyc(4'b1000, 16'h0, 16'h0, 0, 0, 0, 16'h0);
    cyc(4'b0000, 16'h0, 16'h0, 0, 0, 0, 16'h0);
    chk("in_wait_busy", 32'(busy), 32'd1);
    do_reset("wait_reset");
    cyc(4'b0000, 16'h0, 16'h0, 0, 0, 1, 16'h0099);
    chk("late_fill_depth", 32'(depth), 32'd0);
    chk("late_fill_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/data_stack.md
Name: data_stack

Overview:
- Operand stack for the stack-machine datapath, directly downstream of the control FSM.
- Consumes the control FSM's DSOP, to_sr0/to_sr1 and the sr0/sr1 overwrite strobes.
- Produces from_sr0/from_sr1, which feed the ALU and the control FSM, and data_stack_overflow.
- Top two entries live in registers sr0/sr1. Deeper entries live in an on-chip body array. The oldest entries spill to data memory on overflow and are refilled from it on pop.

Parameters:
- WIDTH, 16, data word width.
- DEPTH, 16, on-chip entries including sr0 and sr1 (min 3).
- SPILL_MAX, 1024, maximum entries held in data memory (matches the 10-bit data_mem_ptr).

Ports:
- clk  in  1  clock.
- async_reset  in  1  asynchronous, active-high reset.
- DSOP  in  4  [3] pop, [2] push, [1] write, [0] read.
- to_sr0  in  WIDTH  write/push data for top of stack.
- to_sr1  in  WIDTH  write data for second entry.
- sr0_overwrite  in  1  replace sr0 with to_sr0 this cycle.
- sr1_overwrite  in  1  replace sr1 with to_sr1 this cycle.
- from_sr0  out  WIDTH  current top of stack (registered).
- from_sr1  out  WIDTH  current second entry (registered).
- depth  out  5  on-chip occupancy, 0..DEPTH.
- data_stack_overflow  out  1  1-cycle pulse when an entry spills.
- underflow  out  1  1-cycle pulse on pop of an empty stack.
- spill_valid  out  1  1-cycle strobe; spill_data is valid.
- spill_data  out  WIDTH  evicted bottom entry.
- fill_req  out  1  1-cycle request for the most recently spilled entry.
- fill_valid  in  1  fill_data is valid.
- fill_data  in  WIDTH  refill word from data memory.
- busy  out  1  fill outstanding; ops not accepted.
- op_dropped  out  1  1-cycle pulse; an op or overwrite arrived while busy and was ignored.

Behaviour:
- Reset (async): sr0=sr1=0, depth=0, spill count=0, state IDLE, all pulse/strobe outputs 0, busy=0. Body array contents are don't-care.
- All updates occur on posedge clk. from_sr0/from_sr1 reflect the result one cycle after the op.
- Op decode (IDLE only), by DSOP[3:2]:
  - 01, push: sr1<=sr0; body top<=sr1. sr0<=to_sr0 if DSOP[1], else sr0 is unchanged (dup). depth+1.
  - 10, pop: sr0<=sr1; sr1<=body top (0 if depth<=2). depth-1. DSOP[0] has no extra effect.
  - 00 with DSOP[1], write: sr0<=to_sr0, sr1<=to_sr1, depth unchanged.
  - 11: replace top. sr0<=to_sr0 if DSOP[1], else no change. depth unchanged.
  - 00 with DSOP[1]=0: no-op. DSOP[0] alone is a no-op.
- Overwrite strobes apply after the DSOP shift in the same cycle:
  - sr0_overwrite forces final sr0=to_sr0.
  - sr1_overwrite forces final sr1=to_sr1.
  - Strobes are legal with DSOP=0000.
- Vacated slots read 0: after pop to depth 1, sr1=0; after pop to depth 0, sr0=0.
- Overflow, push at depth==DEPTH:
  - Oldest body entry is driven on spill_data with spill_valid=1 and data_stack_overflow=1 for that cycle.
  - Spill count +1, depth stays DEPTH.
  - If spill count==SPILL_MAX, the entry is lost; the pulses still fire and spill count saturates.
- Underflow, pop at depth==0: underflow pulses, no state change.
- Fill FSM, states IDLE, REQ, WAIT:
  - Entry: a pop that leaves depth==DEPTH-1 with spill count>0 moves IDLE->REQ.
  - REQ: fill_req=1 for one cycle, spill count-1, ->WAIT.
  - WAIT: on fill_valid, fill_data is inserted at the bottom of the body, depth+1, ->IDLE.
  - busy=1 in REQ and WAIT. Any non-zero DSOP or overwrite strobe in REQ/WAIT is ignored and op_dropped pulses.
  - fill_valid in IDLE/REQ is ignored.
- Body array is circular with head/tail pointers mod (DEPTH-2); wrap is invisible externally.
- Reset during WAIT returns to IDLE. A late fill_valid is then ignored, and spilled memory contents are abandoned.

Test Plan:
- Reset, push 0x0005 then 0x0007 (DSOP=0110) -> from_sr0=0x0007, from_sr1=0x0005, depth=2; pop (1001) -> from_sr0=0x0005, from_sr1=0, depth=1.
- DEPTH=16: push 1..17 -> 17th push gives spill_valid=1, spill_data=1, data_stack_overflow=1, depth=16, from_sr0=17.
- Continuing: pop once -> fill_req next cycle, busy=1. Drive fill_valid with 0x0001 two cycles later -> busy=0, depth=16. Then 16 pops return 16..1 in order.
- Issue push while busy -> op_dropped=1, depth and sr0 unchanged. Pop on empty stack -> underflow=1, sr0=0, depth=0.
- sr0=0x0010, sr1=0x0003: DSOP=0010 with to_sr0=0x0003, to_sr1=0x0010 -> swapped values, depth unchanged. Then sr0_overwrite=1 with to_sr0=0x000D alongside pop -> sr0=0x000D, depth-1.
- Assert async_reset mid-WAIT -> all outputs zero immediately. A following fill_valid is ignored and depth stays 0.
